// File: rtl/mux4_rr_arbiter.sv
// mux4_rr_arbiter: round-robin arbiter for a shared 4:1 mux, with hold cap; define MUX4_ARB_LOCK_EN to add a lock input.
module mux4_rr_arbiter #(
  parameter int DATA_W   = 1,
  parameter int MAX_HOLD = 4
) (
  input  logic              clk,
  input  logic              rst,
`ifdef MUX4_ARB_LOCK_EN
  input  logic              lock,
`endif
  input  logic [3:0]        req,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [DATA_W-1:0] c,
  input  logic [DATA_W-1:0] d,
  output logic [3:0]        gnt,
  output logic              s1,
  output logic              s0,
  output logic              valid,
  output logic [DATA_W-1:0] out
);
  typedef enum logic {IDLE, GRANT} state_t;
  localparam logic [3:0] CAP = 4'(MAX_HOLD - 1);
  state_t state, nxt_state;
  logic [1:0] ptr, nxt_ptr, pick, off, nxt_sel;
  logic [3:0] hold, nxt_hold, mask, rot, nxt_gnt;
  logic [7:0] dbl;
  logic others, at_cap, lk, nxt_valid;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ptr   <= 2'd3;
      hold  <= '0;
      gnt   <= '0;
      s1    <= 1'b0;
      s0    <= 1'b0;
      valid <= 1'b0;
    end else begin
      state     <= nxt_state;
      ptr       <= nxt_ptr;
      hold      <= nxt_hold;
      gnt       <= nxt_gnt;
      {s1, s0}  <= nxt_sel;
      valid     <= nxt_valid;
    end
  end
  // While granted, ptr is the owner; its own bit is excluded so "others" means competing requests.
  always_comb begin
    mask   = (state == GRANT) ? req & ~(4'b1 << ptr) : req;
    dbl    = {mask, mask};
    rot    = 4'(dbl >> (3'(ptr) + 3'd1));
    off    = rot[0] ? 2'd0 : rot[1] ? 2'd1 : rot[2] ? 2'd2 : 2'd3;
    pick   = ptr + 2'd1 + off;
    others = |mask;
    at_cap = hold == CAP;
`ifdef MUX4_ARB_LOCK_EN
    lk     = lock;
`else
    lk     = 1'b0;
`endif
    nxt_state = state;
    nxt_ptr   = ptr;
    nxt_hold  = at_cap ? hold : hold + 4'd1;
    if (state == IDLE || !req[ptr] || (at_cap && others && !lk)) begin
      nxt_state = others ? GRANT : IDLE;
      nxt_ptr   = others ? pick : ptr;
      nxt_hold  = '0;
    end
  end
  always_comb begin
    nxt_valid = nxt_state == GRANT;
    nxt_gnt   = nxt_valid ? 4'b1 << nxt_ptr : 4'b0;
    nxt_sel   = nxt_valid ? nxt_ptr : 2'd0;
  end
  assign out = !valid ? '0 : s1 ? (s0 ? d : c) : (s0 ? b : a);
endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// tb_mux4_rr_arbiter: table-driven scoreboard bench for mux4_rr_arbiter (DATA_W=4, MAX_HOLD=4).
module tb_mux4_rr_arbiter;
  localparam int W = 4;
  logic clk = 1'b0, rst = 1'b1;
`ifdef MUX4_ARB_LOCK_EN
  logic lock = 1'b0;
`endif
  logic [3:0] req = '0;
  logic [W-1:0] a = 4'hA, b = 4'hB, c = 4'hC, d = 4'hD;
  logic [3:0] gnt;
  logic s1, s0, valid;
  logic [W-1:0] out;
  typedef struct {
    logic       rst;
    logic       lock;
    logic [3:0] req;
    logic [3:0] gnt;
  } vec_t;
  vec_t vecs[$];
  logic [3:0] sb[$];
  int compared = 0, mismatched = 0;

  mux4_rr_arbiter #(.DATA_W(W), .MAX_HOLD(4)) dut (
    .clk(clk), .rst(rst),
`ifdef MUX4_ARB_LOCK_EN
    .lock(lock),
`endif
    .req(req), .a(a), .b(b), .c(c), .d(d),
    .gnt(gnt), .s1(s1), .s0(s0), .valid(valid), .out(out)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] enc(input logic [3:0] g);
    return g[3] ? 2'd3 : g[2] ? 2'd2 : g[1] ? 2'd1 : 2'd0;
  endfunction

  function automatic logic [W-1:0] data_of(input logic [3:0] g);
    return g == 4'b0001 ? a : g == 4'b0010 ? b : g == 4'b0100 ? c : g == 4'b1000 ? d : '0;
  endfunction

  task automatic add(input logic r, input logic l, input logic [3:0] q, input logic [3:0] g, input int n);
    vec_t v;
    v.rst = r; v.lock = l; v.req = q; v.gnt = g;
    for (int i = 0; i < n; i++) vecs.push_back(v);
  endtask

  initial begin
    logic [3:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("gnt", 32'(gnt), 32'(e));
        check("sel", 32'({s1, s0}), 32'(enc(e)));
        check("valid", 32'(valid), 32'(|e));
        check("out", 32'(out), 32'(data_of(e)));
      end
    end
  end

  initial begin
    // reset with all requests, then fairness: each owner exactly 4 cycles, no gaps
    add(1, 0, 4'b1111, 4'b0000, 2);
    add(0, 0, 4'b1111, 4'b0001, 4);
    add(0, 0, 4'b1111, 4'b0010, 4);
    add(0, 0, 4'b1111, 4'b0100, 4);
    add(0, 0, 4'b1111, 4'b1000, 4);
    add(0, 0, 4'b1111, 4'b0001, 1);
    // lone requester holds indefinitely, then releases to idle
    add(1, 0, 4'b0000, 4'b0000, 1);
    add(0, 0, 4'b0100, 4'b0100, 11);
    add(0, 0, 4'b0000, 4'b0000, 2);
    // release with another pending hands over without a bubble
    add(0, 0, 4'b0010, 4'b0010, 1);
    add(0, 0, 4'b1010, 4'b0010, 1);
    add(0, 0, 4'b1000, 4'b1000, 1);
    // forced rotation wraps 3 -> 0, mid-grant reset, then 0 wins
    add(0, 0, 4'b1001, 4'b1000, 3);
    add(0, 0, 4'b1001, 4'b0001, 1);
    add(1, 0, 4'b1001, 4'b0000, 1);
    add(0, 0, 4'b1001, 4'b0001, 4);
    add(0, 0, 4'b1001, 4'b1000, 1);
    add(0, 0, 4'b0001, 4'b0001, 3);
`ifdef MUX4_ARB_LOCK_EN
    add(1, 0, 4'b0000, 4'b0000, 1);
    add(0, 0, 4'b0100, 4'b0100, 1);
    add(0, 1, 4'b0101, 4'b0100, 8);
    add(0, 0, 4'b0101, 4'b0001, 1);
    add(0, 1, 4'b0000, 4'b0000, 1);
`endif
    foreach (vecs[i]) begin
      @(negedge clk);
      rst = vecs[i].rst;
      req = vecs[i].req;
`ifdef MUX4_ARB_LOCK_EN
      lock = vecs[i].lock;
`endif
      sb.push_back(vecs[i].gnt);
    end
    repeat (2) @(negedge clk);
    // out follows data combinationally while the grant holds
    rst = 1'b0;
    req = 4'b0010;
    @(negedge clk);
    @(negedge clk);
    b = 4'h5;
    #1 check("out_comb", 32'(out), 32'h5);
    b = 4'h3;
    #1 check("out_comb2", 32'(out), 32'h3);
    repeat (2) @(negedge clk);
    if (sb.size() != 0) begin
      mismatched++;
      $display("FAIL drain: %0d entries left expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
